// File: rtl/video_stream_pkg.sv
// Shared types for the video stream conditioning path: pixel type, aligner
// state encoding, default pad pixel and line-width clamp helper.
package video_stream_pkg;

  localparam int unsigned PIXEL_WIDTH = 24;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  localparam pixel_t PAD_VALUE_DEFAULT = '0;

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    PAD,
    PAD_SOF,
    DROP
  } align_state_t;

  // A zero width would never produce tlast, so the minimum legal line is one pixel.
  function automatic int unsigned clamp_width(input int unsigned w, input int unsigned max_w);
    if (w == 0) return 1;
    if (w > max_w) return max_w;
    return w;
  endfunction

endpackage

// File: rtl/stream_video_skid_buf.sv
// Two-entry register slice: registered outputs, registered ready, full
// throughput, output held stable while valid and not ready.
module stream_video_skid_buf #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             m_valid_d;
  logic [WIDTH-1:0] m_data_d;
  logic             skid_valid_d;
  logic [WIDTH-1:0] skid_data_d;
  logic             s_fire;

  assign s_fire = s_valid & s_ready;

  always_comb begin
    m_valid_d    = m_valid;
    m_data_d     = m_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (m_ready || !m_valid) begin
      if (skid_valid) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data;
        skid_valid_d = 1'b0;
      end else begin
        m_valid_d = s_fire;
        if (s_fire) m_data_d = s_data;
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  // Ready is registered from the next skid occupancy so it stays low through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
    end else begin
      m_valid    <= m_valid_d;
      m_data     <= m_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      s_ready    <= ~skid_valid_d;
    end
  end

endmodule

// File: rtl/stream_video_frame_aligner.sv
// AXI4-Stream video line/frame aligner: enforces tuser on SOF and exactly
// cfg_width beats per line. Define VIDEO_ALIGN_STATS_EN for error counters.
module stream_video_frame_aligner
  import video_stream_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 24,
  parameter int unsigned           MAX_IMG_RES = 2048,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = DATA_WIDTH'(PAD_VALUE_DEFAULT),
  localparam int unsigned          CW          = $clog2(MAX_IMG_RES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW-1:0]         cfg_width,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  err_early_eol,
  output logic                  err_late_eol,
  output logic                  err_sof
`ifdef VIDEO_ALIGN_STATS_EN
  ,
  output logic [15:0]           err_early_cnt,
  output logic [15:0]           err_late_cnt,
  output logic [15:0]           err_sof_cnt
`endif
);

  align_state_t          state, state_d;
  logic [CW-1:0]         col, col_d;
  logic [CW-1:0]         width_q, width_d;
  logic [CW-1:0]         cfg_clamped;
  logic [CW-1:0]         line_w;
  logic                  core_valid;
  logic                  core_ready;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_user;
  logic                  core_last;

  assign cfg_clamped = CW'(clamp_width(32'(cfg_width), MAX_IMG_RES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_SOF;
      col     <= '0;
      width_q <= CW'(1);
    end else begin
      state   <= state_d;
      col     <= col_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    state_d             = state;
    col_d               = col;
    width_d             = width_q;
    line_w              = width_q;
    s_axis_video_tready = 1'b0;
    core_valid          = 1'b0;
    core_data           = s_axis_video_tdata;
    core_user           = 1'b0;
    core_last           = 1'b0;
    err_early_eol       = 1'b0;
    err_late_eol        = 1'b0;
    err_sof             = 1'b0;
    case (state)
      WAIT_SOF: begin
        s_axis_video_tready = core_ready;
        if (core_ready && s_axis_video_tvalid && s_axis_video_tuser) begin
          core_valid = 1'b1;
          core_user  = 1'b1;
          width_d    = cfg_clamped;
          state_d    = PASS;
          if (cfg_clamped == CW'(1)) begin
            core_last = 1'b1;
            col_d     = '0;
          end else begin
            col_d = CW'(1);
          end
        end
      end
      PASS: begin
        if (s_axis_video_tvalid && s_axis_video_tuser && col != '0) begin
          // Mid-line SOF is left pending; the line is padded out before taking it.
          err_sof = 1'b1;
          state_d = PAD_SOF;
        end else begin
          s_axis_video_tready = core_ready;
          if (s_axis_video_tuser) line_w = cfg_clamped;
          if (core_ready && s_axis_video_tvalid) begin
            core_valid = 1'b1;
            core_user  = s_axis_video_tuser;
            if (s_axis_video_tuser) width_d = cfg_clamped;
            if (col == line_w - CW'(1)) begin
              core_last = 1'b1;
              col_d     = '0;
              if (!s_axis_video_tlast) begin
                err_late_eol = 1'b1;
                state_d      = DROP;
              end
            end else begin
              col_d = col + CW'(1);
              if (s_axis_video_tlast) begin
                err_early_eol = 1'b1;
                state_d       = PAD;
              end
            end
          end
        end
      end
      PAD, PAD_SOF: begin
        if (core_ready) begin
          core_valid = 1'b1;
          core_data  = PAD_VALUE;
          if (col == width_q - CW'(1)) begin
            core_last = 1'b1;
            col_d     = '0;
            state_d   = PASS;
          end else begin
            col_d = col + CW'(1);
          end
        end
      end
      DROP: begin
        if (s_axis_video_tvalid && s_axis_video_tuser) begin
          state_d = PASS;
        end else begin
          s_axis_video_tready = 1'b1;
          if (s_axis_video_tvalid && s_axis_video_tlast) state_d = PASS;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  stream_video_skid_buf #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .s_valid(core_valid),
    .s_ready(core_ready),
    .s_data ({core_data, core_user, core_last}),
    .m_valid(m_axis_video_tvalid),
    .m_ready(m_axis_video_tready),
    .m_data ({m_axis_video_tdata, m_axis_video_tuser, m_axis_video_tlast})
  );

`ifdef VIDEO_ALIGN_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_early_cnt <= '0;
      err_late_cnt  <= '0;
      err_sof_cnt   <= '0;
    end else begin
      if (err_early_eol && err_early_cnt != '1) err_early_cnt <= err_early_cnt + 16'd1;
      if (err_late_eol && err_late_cnt != '1)   err_late_cnt  <= err_late_cnt + 16'd1;
      if (err_sof && err_sof_cnt != '1)         err_sof_cnt   <= err_sof_cnt + 16'd1;
    end
  end
`endif

endmodule
